// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based request issue, in-order response capture, redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        InstrValidF,
  input  logic        StallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;   // address of the next kept response
  logic [CW-1:0] occ_q, occ_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [CW+1:0] used;
  logic req_hs, rsp_kept, rsp_drop, byp, push, pop, rsp_any;

  always_comb begin
    used           = (CW+2)'(occ_q) + (CW+2)'(inflight_q) + (CW+2)'(drop_q);
    imem_req_valid = reset && !redirect && (used < DEPTH_C);
    imem_req_addr  = fetch_pc_q;
    req_hs         = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_q != '0);
    rsp_kept       = imem_rsp_valid && (drop_q == '0) && (inflight_q != '0) && !redirect;
    rsp_any        = imem_rsp_valid && ((drop_q != '0) || (inflight_q != '0));
`ifdef FETCH_QUEUE_BYPASS_EN
    byp            = rsp_kept && (occ_q == '0) && !StallF;
`else
    byp            = 1'b0;
`endif
    InstrValidF = (occ_q != '0) || byp;
    if (occ_q != '0) begin
      InstrF = instr_mem_q[head_q];
      PCF    = pc_mem_q[head_q];
    end else if (byp) begin
      InstrF = imem_rsp_data;
      PCF    = rsp_pc_q;
    end else begin
      InstrF = NOP;
      PCF    = fetch_pc_q;
    end
    pop  = (occ_q != '0) && !StallF && !redirect;
    push = rsp_kept && !byp;

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redirect) begin
      // Everything still owed by memory becomes drop credit, minus a response landing now.
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rsp_pc_d   = redirect_pc & 32'hFFFF_FFFC;
      occ_d      = '0;
      inflight_d = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = drop_q + inflight_q - CW'(rsp_any);
    end else begin
      if (req_hs)   fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_kept) rsp_pc_d   = rsp_pc_q + 32'd4;
      inflight_d = inflight_q + CW'(req_hs) - CW'(rsp_kept);
      drop_d     = drop_q - CW'(rsp_drop);
      occ_d      = occ_q + CW'(push) - CW'(pop);
      if (pop)  head_d = head_q + AW'(1);
      if (push) tail_d = tail_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      occ_q      <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Storage is qualified by occ, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      pc_mem_q[tail_q]    <= rsp_pc_q;
      instr_mem_q[tail_q] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order instruction memory model (1-cycle when enabled).
module tb_fetch_queue;
  localparam logic [31:0] K   = 32'h0050_0053;  // memory returns addr + K
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int FIRST = 2;
`else
  localparam int FIRST = 3;
`endif

  logic        clk = 1'b0, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrF, PCF;
  logic        InstrValidF, StallF, redirect;
  logic [31:0] redirect_pc;
  logic        rsp_en;
  logic [31:0] mq[$];
  int          total = 0, passed = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrF(InstrF), .PCF(PCF), .InstrValidF(InstrValidF),
    .StallF(StallF), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (rsp_en && mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mq[0] + K;
        void'(mq.pop_front());
      end
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input logic rdy, input logic stl);
    reset = 1'b0; imem_req_ready = 1'b0; StallF = stl; redirect = 1'b0;
    redirect_pc = '0; rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    imem_req_ready = rdy;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; imem_req_ready = 1'b1; StallF = 1'b1; redirect = 1'b0;
    redirect_pc = '0; rsp_en = 1'b1;
    @(negedge clk); #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", imem_req_valid); else passed++;
    total++; if (InstrValidF !== 1'b0) $display("FAIL rst_valid got %b want 0", InstrValidF); else passed++;
    total++; if (InstrF !== NOP) $display("FAIL rst_instr got %h want %h", InstrF, NOP); else passed++;
    total++; if (PCF !== 32'h0) $display("FAIL rst_pc got %h want 0", PCF); else passed++;
    do_reset(1'b1, 1'b1);
    repeat (6) @(negedge clk);
    #1;
    total++; if (InstrValidF !== 1'b1) $display("FAIL pre_rst_fill got %b want 1", InstrValidF); else passed++;
    #1 reset = 1'b0;
    #1;
    total++; if (InstrValidF !== 1'b0) $display("FAIL async_rst_valid got %b want 0", InstrValidF); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL async_rst_req got %b want 0", imem_req_valid); else passed++;
    total++; if (PCF !== 32'h0) $display("FAIL async_rst_pc got %h want 0", PCF); else passed++;
  endtask

  task automatic test_fetch;
    do_reset(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 4) begin
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*c))
          $display("FAIL fetch_addr c%0d got v=%b a=%h want v=1 a=%h", c, imem_req_valid, imem_req_addr, 32'(4*c));
        else passed++;
      end
      total++;
      if (InstrValidF !== (c >= FIRST)) $display("FAIL fetch_valid c%0d got %b want %b", c, InstrValidF, c >= FIRST);
      else passed++;
      if (c == FIRST) begin
        total++;
        if (PCF !== 32'h0 || InstrF !== K) $display("FAIL fetch_first got pc=%h i=%h want pc=0 i=%h", PCF, InstrF, K);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    int n = 0, pops = 0;
    logic got_req = 1'b0;
    do_reset(1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (imem_req_valid && imem_req_ready) n++;
      @(negedge clk);
    end
    #1;
    total++; if (n !== 4) $display("FAIL stall_req_count got %0d want 4", n); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_full_req got %b want 0", imem_req_valid); else passed++;
    StallF = 1'b0;
    for (int c = 0; c < 12 && pops < 4; c++) begin
      #1;
      if (!got_req && imem_req_valid) begin
        got_req = 1'b1;
        total++;
        if (imem_req_addr !== 32'h10) $display("FAIL stall_resume got %h want 00000010", imem_req_addr); else passed++;
      end
      if (InstrValidF) begin
        total++;
        if (PCF !== 32'(4*pops) || InstrF !== 32'(4*pops) + K)
          $display("FAIL stall_pop%0d got pc=%h i=%h want pc=%h", pops, PCF, InstrF, 32'(4*pops));
        else passed++;
        pops++;
      end
      @(negedge clk);
    end
    total++; if (pops !== 4 || !got_req) $display("FAIL stall_drain got pops=%0d req=%b want 4,1", pops, got_req); else passed++;
  endtask

  task automatic test_redirect;
    logic found = 1'b0;
    do_reset(1'b1, 1'b0);
    rsp_en = 1'b0;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h203;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL redir_req got %b want 0", imem_req_valid); else passed++;
    @(negedge clk);
    redirect = 1'b0; rsp_en = 1'b1; imem_req_ready = 1'b1;
    #1;
    total++;
    if (InstrValidF !== 1'b0 || PCF !== 32'h200 || imem_req_addr !== 32'h200)
      $display("FAIL redir_empty got v=%b pc=%h a=%h want v=0 pc=200 a=200", InstrValidF, PCF, imem_req_addr);
    else passed++;
    for (int c = 0; c < 20 && !found; c++) begin
      if (InstrValidF) begin
        found = 1'b1;
        total++;
        if (PCF !== 32'h200 || InstrF !== 32'h200 + K) $display("FAIL redir_first got pc=%h i=%h want pc=200", PCF, InstrF);
        else passed++;
      end
      @(negedge clk); #1;
    end
    total++; if (!found) $display("FAIL redir_timeout got none want valid"); else passed++;
  endtask

  task automatic test_redirect_rsp;
    logic found = 1'b0;
    do_reset(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk); #1;
    total++; if (InstrValidF !== 1'b1 || PCF !== 32'h0) $display("FAIL rr_head got v=%b pc=%h want 1,0", InstrValidF, PCF); else passed++;
    StallF = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rr_req got %b want 0", imem_req_valid); else passed++;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    total++; if (InstrValidF !== 1'b0 || PCF !== 32'h100) $display("FAIL rr_flush got v=%b pc=%h want 0,100", InstrValidF, PCF); else passed++;
    imem_req_ready = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) $display("FAIL rr_refetch got v=%b a=%h want 1,100", imem_req_valid, imem_req_addr); else passed++;
    for (int c = 0; c < 20 && !found; c++) begin
      if (InstrValidF) begin
        found = 1'b1;
        total++;
        if (PCF !== 32'h100) $display("FAIL rr_first got pc=%h want 00000100", PCF); else passed++;
      end
      @(negedge clk); #1;
    end
    total++; if (!found) $display("FAIL rr_timeout got none want valid"); else passed++;
  endtask

  task automatic test_push_pop;
    int n = 0;
    do_reset(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    StallF = 1'b0;
    #1;
    total++; if (InstrValidF !== 1'b1 || PCF !== 32'h0) $display("FAIL pp_head got v=%b pc=%h want 1,0", InstrValidF, PCF); else passed++;
    @(negedge clk);
    StallF = 1'b1;
    #1;
    total++; if (PCF !== 32'h4 || InstrF !== 32'h4 + K) $display("FAIL pp_after got pc=%h i=%h want pc=4", PCF, InstrF); else passed++;
    @(negedge clk);
    StallF = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (InstrValidF) begin
        total++;
        if (PCF !== 32'(4 + 4*n)) $display("FAIL pp_pop%0d got %h want %h", n, PCF, 32'(4 + 4*n)); else passed++;
        n++;
      end
      @(negedge clk);
    end
    total++; if (n !== 2) $display("FAIL pp_occ got %0d pops want 2", n); else passed++;
  endtask

  task automatic test_wrap;
    do_reset(1'b0, 1'b1);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    total++; if (imem_req_addr !== 32'hFFFF_FFFC || PCF !== 32'hFFFF_FFFC) $display("FAIL wrap_pre got a=%h pc=%h want fffffffc", imem_req_addr, PCF); else passed++;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #1;
    total++; if (imem_req_addr !== 32'h0) $display("FAIL wrap_next got %h want 00000000", imem_req_addr); else passed++;
  endtask

  task automatic test_bypass;
    do_reset(1'b0, 1'b0);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk); #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    total++;
    if (InstrValidF !== 1'b1 || InstrF !== 32'h0050_0093 || PCF !== 32'h40)
      $display("FAIL byp_same got v=%b i=%h pc=%h want 1,00500093,40", InstrValidF, InstrF, PCF);
    else passed++;
    @(negedge clk); #1;
    total++; if (InstrValidF !== 1'b0 || PCF !== 32'h44) $display("FAIL byp_consumed got v=%b pc=%h want 0,44", InstrValidF, PCF); else passed++;
`else
    total++;
    if (InstrValidF !== 1'b0 || InstrF !== NOP || PCF !== 32'h44)
      $display("FAIL lat_rsp_cycle got v=%b i=%h pc=%h want 0,00000013,44", InstrValidF, InstrF, PCF);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (InstrValidF !== 1'b1 || InstrF !== 32'h0050_0093 || PCF !== 32'h40)
      $display("FAIL lat_next got v=%b i=%h pc=%h want 1,00500093,40", InstrValidF, InstrF, PCF);
    else passed++;
`endif
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_stall;
    test_redirect;
    test_redirect_rsp;
    test_push_pop;
    test_wrap;
    test_bypass;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
